// File: rtl/mux_stream_pkg.sv
// mux_stream_pkg: mode encoding and channel-index helpers shared by mux_n_1_stream
package mux_stream_pkg;
  typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mux_mode_e;
  // Channel after i, wrapping at n
  function automatic int unsigned next_idx(input int unsigned i, input int unsigned n);
    return (i + 1) % n;
  endfunction
  // Index width that never collapses to zero bits
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mux_rr_pick.sv
// mux_rr_pick: rotating-priority finder, first set req at or after ptr (mod N)
module mux_rr_pick #(
  parameter int N = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          gnt_vld,
  output logic [SW-1:0] gnt_idx
);
  // Scan furthest to nearest so the request closest to ptr wins
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[ptr + SW'(k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = ptr + SW'(k);
      end
    end
  end
endmodule

// File: rtl/mux_n_1_stream.sv
// mux_n_1_stream: N:1 valid/ready stream mux with one registered output stage,
// fixed-select or round-robin arbitration. Define MUX_N_1_STREAM_LAST_EN to add
// in_last/out_last and keep round-robin grants packet-atomic.
module mux_n_1_stream
  import mux_stream_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 4,
  localparam int SW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  in_valid,
  input  logic [W-1:0]  in_data [N],
`ifdef MUX_N_1_STREAM_LAST_EN
  input  logic [N-1:0]  in_last,
  output logic          out_last,
`endif
  output logic [N-1:0]  in_ready,
  input  logic          mode,
  input  logic [SW-1:0] sel,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic [SW-1:0] out_chan,
  input  logic          out_ready
);
  logic [SW-1:0] rr_ptr, rr_idx, gnt, lock_chan;
  logic rr_vld, gnt_vld, load, xfer, is_rr, lock_on;
  assign is_rr = mode == MODE_RR;
  mux_rr_pick #(.N(N), .SW(SW)) u_pick (
    .req(in_valid),
    .ptr(rr_ptr),
    .gnt_vld(rr_vld),
    .gnt_idx(rr_idx)
  );
  assign gnt = lock_on ? lock_chan : is_rr ? rr_idx : sel;
  assign gnt_vld = lock_on ? in_valid[lock_chan] : is_rr ? rr_vld : in_valid[sel];
  assign load = !out_valid || out_ready;
  assign xfer = rst && load && gnt_vld;
  assign in_ready = xfer ? N'(1) << gnt : '0;
  // Output register and round-robin pointer; a held beat stays put until consumed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_chan <= '0;
      rr_ptr <= '0;
    end else begin
      if (load) out_valid <= gnt_vld;
      if (xfer) begin
        out_data <= in_data[gnt];
        out_chan <= gnt;
        if (is_rr) rr_ptr <= SW'(next_idx(int'(gnt), N));
      end
    end
  end
`ifdef MUX_N_1_STREAM_LAST_EN
  logic locked;
  assign lock_on = is_rr && locked;
  // Packet lock: round-robin grant stays on a channel until its last beat moves
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      locked <= 1'b0;
      lock_chan <= '0;
      out_last <= 1'b0;
    end else begin
      if (!is_rr) locked <= 1'b0;
      if (xfer) begin
        out_last <= in_last[gnt];
        if (is_rr) begin
          locked <= !in_last[gnt];
          lock_chan <= gnt;
        end
      end
    end
  end
`else
  assign lock_on = 1'b0;
  assign lock_chan = '0;
`endif
endmodule

// File: tb/tb_mux_n_1_stream.sv
// tb_mux_n_1_stream: directed table, reset/packet sequences and randomized model check
module tb_mux_n_1_stream;
  localparam int N = 4, W = 8, SW = 2;
  logic clk = 0, rst = 0;
  logic [N-1:0] in_valid = '0, in_ready, xm;
  logic [W-1:0] in_data [N];
  logic mode = 0, out_valid, out_ready = 1;
  logic [SW-1:0] sel = 0, out_chan;
  logic [W-1:0] out_data;
`ifdef MUX_N_1_STREAM_LAST_EN
  logic [N-1:0] in_last = '1;
  logic out_last;
`endif
  int vectors = 0, errors = 0;
  logic m_ov, m_locked, m_last;
  logic [W-1:0] m_data;
  int m_chan, m_ptr, m_lchan;

  typedef struct {
    logic md; logic [SW-1:0] s; logic [N-1:0] v; logic ordy;
    logic [N-1:0] rdy; logic ov; logic [SW-1:0] ch;
  } vec_t;
  vec_t tbl [16];

  always #5 clk = ~clk;

  mux_n_1_stream #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
`ifdef MUX_N_1_STREAM_LAST_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_valid(out_valid),
    .out_data(out_data), .out_chan(out_chan), .out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic md, input logic [SW-1:0] s, input logic [N-1:0] v,
                       input logic ordy, input logic [N-1:0] rdy, input logic ov,
                       input logic [SW-1:0] ch, input string tag);
    mode = md; sel = s; in_valid = v; out_ready = ordy;
    #1 chk({tag, " in_ready"}, in_ready, rdy);
    @(posedge clk); #1;
    chk({tag, " out_valid"}, out_valid, ov);
    if (ov) begin
      chk({tag, " out_chan"}, out_chan, ch);
      chk({tag, " out_data"}, out_data, 8'hA0 + ch);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk); rst = 0; #1;
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " in_ready"}, in_ready, 0);
    chk({tag, " out_data"}, out_data, 0);
    chk({tag, " out_chan"}, out_chan, 0);
`ifdef MUX_N_1_STREAM_LAST_EN
    chk({tag, " out_last"}, out_last, 0);
`endif
    @(negedge clk); rst = 1; in_valid = '0;
    @(posedge clk); #1;
    m_ov = 0; m_ptr = 0; m_locked = 0; m_data = 0; m_chan = 0; m_last = 0; m_lchan = 0;
  endtask

  task automatic model_cycle(output logic [N-1:0] x);
    int g;
    logic gv, ld;
    #1;
    g = sel; gv = in_valid[sel];
    if (mode && m_locked) begin
      g = m_lchan; gv = in_valid[g];
    end else if (mode) begin
      gv = 0;
      for (int k = 0; k < N; k++)
        if (!gv && in_valid[(m_ptr + k) % N]) begin gv = 1; g = (m_ptr + k) % N; end
    end
    ld = !m_ov || out_ready;
    x = (ld && gv) ? N'(1) << g : '0;
    chk("rand in_ready", in_ready, x);
    @(posedge clk);
    if (ld) m_ov = gv;
    if (ld && gv) begin
      m_data = in_data[g]; m_chan = g;
      if (mode) m_ptr = (g + 1) % N;
`ifdef MUX_N_1_STREAM_LAST_EN
      m_last = in_last[g];
      if (mode) begin m_locked = !in_last[g]; m_lchan = g; end
`endif
    end
    if (!mode) m_locked = 0;
    #1;
    chk("rand out_valid", out_valid, m_ov);
    if (m_ov) begin
      chk("rand out_data", out_data, m_data);
      chk("rand out_chan", out_chan, m_chan);
`ifdef MUX_N_1_STREAM_LAST_EN
      chk("rand out_last", out_last, m_last);
`endif
    end
  endtask

  initial begin
    tbl[0]  = '{1'b0, 2'd2, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2};
    tbl[1]  = '{1'b0, 2'd1, 4'hD, 1'b1, 4'h0, 1'b0, 2'd0};
    tbl[2]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0};
    tbl[3]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1};
    tbl[4]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2};
    tbl[5]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3};
    tbl[6]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0};
    tbl[7]  = '{1'b1, 2'd0, 4'h2, 1'b1, 4'h2, 1'b1, 2'd1};
    tbl[8]  = '{1'b1, 2'd0, 4'hA, 1'b1, 4'h8, 1'b1, 2'd3};
    tbl[9]  = '{1'b1, 2'd0, 4'hA, 1'b1, 4'h2, 1'b1, 2'd1};
    tbl[10] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'h8, 1'b1, 2'd3};
    tbl[11] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd3};
    tbl[12] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd3};
    tbl[13] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd3};
    tbl[14] = '{1'b1, 2'd0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0};
    tbl[15] = '{1'b1, 2'd0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0};
    for (int i = 0; i < N; i++) in_data[i] = W'(8'hA0 + i);
    in_valid = '1;
    #2;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_chan", out_chan, 0);
    chk("reset in_ready", in_ready, 0);
    @(negedge clk); rst = 1; in_valid = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++)
      apply(tbl[i].md, tbl[i].s, tbl[i].v, tbl[i].ordy, tbl[i].rdy, tbl[i].ov, tbl[i].ch,
            $sformatf("tbl%0d", i));
    apply(1'b1, 2'd0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, "pre-rst");
    do_reset("midrst");
    apply(1'b1, 2'd0, 4'h6, 1'b1, 4'h2, 1'b1, 2'd1, "post-rst");
    do_reset("rnd-rst");
    for (int c = 0; c < 400; c++) begin
      model_cycle(xm);
      for (int i = 0; i < N; i++)
        if (xm[i] || !in_valid[i]) begin
          in_valid[i] = ($urandom % 3) != 0;
          in_data[i] = W'($urandom);
`ifdef MUX_N_1_STREAM_LAST_EN
          in_last[i] = ($urandom % 3) == 0;
`endif
        end
      if ($urandom % 16 == 0) mode = ~mode;
      sel = SW'($urandom);
      out_ready = ($urandom % 4) != 0;
    end
`ifdef MUX_N_1_STREAM_LAST_EN
    for (int i = 0; i < N; i++) in_data[i] = W'(8'hA0 + i);
    in_last = '1;
    do_reset("pkt-rst");
    in_last = 4'b0010;
    apply(1'b1, 2'd0, 4'h3, 1'b1, 4'h1, 1'b1, 2'd0, "pkt beat1");
    chk("pkt beat1 out_last", out_last, 0);
    apply(1'b1, 2'd0, 4'h3, 1'b1, 4'h1, 1'b1, 2'd0, "pkt beat2");
    chk("pkt beat2 out_last", out_last, 0);
    apply(1'b1, 2'd0, 4'h2, 1'b1, 4'h0, 1'b0, 2'd0, "pkt idle");
    in_last = 4'b0011;
    apply(1'b1, 2'd0, 4'h3, 1'b1, 4'h1, 1'b1, 2'd0, "pkt beat3");
    chk("pkt beat3 out_last", out_last, 1);
    apply(1'b1, 2'd0, 4'h2, 1'b1, 4'h2, 1'b1, 2'd1, "pkt ch1");
    chk("pkt ch1 out_last", out_last, 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
